input_conditioner: RTL

//  Upstream front end for the stopwatch core. Takes raw btnS, btnR, sw[1:0] from board pins.

---
 rtl/input_conditioner_if.sv | 28 ++
 rtl/input_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
// Board-pin bundle for the stopwatch input conditioner.
// The raw button/switch pins flow toward the conditioner. The clean levels
// and pulses flow back toward the stopwatch core.
interface input_conditioner_if;
  // raw pins, asynchronous to clk
  logic       btnS;
  logic       btnR;
  logic [1:0] sw;        // sw[0]=adj, sw[1]=sel
  // conditioned outputs
  logic       pause;
  logic       reset_req;
  logic       adj;
  logic       sel;
  logic       press_s;
  logic       press_r;

  // Board/core side: drives raw pins, consumes conditioned signals
  modport master (
    output btnS, btnR, sw,
    input  pause, reset_req, adj, sel, press_s, press_r
  );

  // Conditioner side: consumes raw pins, produces conditioned signals
  modport slave (
    input  btnS, btnR, sw,
    output pause, reset_req, adj, sel, press_s, press_r
  );
endinterface

// File: rtl/input_conditioner.sv
// Input conditioner for the stopwatch core.
// Each raw pin is brought into the clk domain with a two-flop synchronizer,
// then debounced on a shared slow sample tick. A level only changes after
// STABLE_SAMPLES consecutive ticks disagree with it; any agreeing tick in
// between restarts the count. Rising edges of the debounced buttons become
// one-clk pulses, and the pause state toggles on each accepted btnS press.
module input_conditioner #(
  parameter int SAMPLE_DIV     = 100000,  // clk cycles per sample tick, >= 2
  parameter int STABLE_SAMPLES = 4        // mismatching ticks to change a level, >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   io
);

  localparam int NIN     = 4;
  localparam int IDX_S   = 0;   // btnS
  localparam int IDX_R   = 1;   // btnR
  localparam int IDX_ADJ = 2;   // sw[0]
  localparam int IDX_SEL = 3;   // sw[1]

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);

  localparam logic [TW-1:0] TICK_MAX = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_SAMPLES - 1);

  // Raw pins packed in a fixed order so every input shares one pipeline
  logic [NIN-1:0] raw;
  assign raw = {io.sw[1], io.sw[0], io.btnR, io.btnS};

  // ------------------------------------------------------------------
  // Two-flop synchronizer; only sync2_q is used downstream
  // ------------------------------------------------------------------
  logic [NIN-1:0] sync1_q;
  logic [NIN-1:0] sync2_q;

  // Bring the asynchronous pins into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // ------------------------------------------------------------------
  // Shared sample tick: one clk wide, once every SAMPLE_DIV clks
  // ------------------------------------------------------------------
  logic [TW-1:0] cnt_t_q;
  logic [TW-1:0] cnt_t_d;
  logic          tick;

  assign tick = (cnt_t_q == TICK_MAX);

  // Free-running divider, wraps at SAMPLE_DIV-1
  always_comb begin
    cnt_t_d = cnt_t_q + 1'b1;
    if (tick) begin
      cnt_t_d = '0;
    end
  end

  // Divider state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_t_q <= '0;
    end else begin
      cnt_t_q <= cnt_t_d;
    end
  end

  // ------------------------------------------------------------------
  // Per-input debouncer
  // ------------------------------------------------------------------
  logic [NIN-1:0] deb;

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_deb
      logic          deb_q;
      logic          deb_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // On a tick: agreement clears the count, the last mismatch flips the
      // level, any other mismatch advances the count. Idle between ticks.
      always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (tick) begin
          if (sync2_q[gi] == deb_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            deb_d = sync2_q[gi];
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Debounced level and its stability count
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          deb_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          deb_q <= deb_d;
          cnt_q <= cnt_d;
        end
      end

      assign deb[gi] = deb_q;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Edge detection, press pulses and pause state
  // ------------------------------------------------------------------
  logic [NIN-1:0] deb_d1_q;   // debounced levels delayed one clk
  logic [NIN-1:0] rise;
  logic           press_s_q;
  logic           press_r_q;
  logic           pause_q;
  logic           pause_d;

  assign rise = deb & ~deb_d1_q;

  // Pause follows the same rising edges that fire the pulses, so it changes
  // on the very edge press_s/press_r go high. A reset press wins over a
  // simultaneous pause press, and pause presses are ignored while the reset
  // button is held.
  always_comb begin
    pause_d = pause_q;
    if (rise[IDX_R]) begin
      pause_d = 1'b0;
    end else if (rise[IDX_S] && !deb[IDX_R]) begin
      pause_d = ~pause_q;
    end
  end

  // Register edge pulses and pause; falling edges produce nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_d1_q  <= '0;
      press_s_q <= 1'b0;
      press_r_q <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      deb_d1_q  <= deb;
      press_s_q <= rise[IDX_S];
      press_r_q <= rise[IDX_R];
      pause_q   <= pause_d;
    end
  end

  assign io.pause     = pause_q;
  assign io.reset_req = deb[IDX_R];
  assign io.adj       = deb[IDX_ADJ];
  assign io.sel       = deb[IDX_SEL];
  assign io.press_s   = press_s_q;
  assign io.press_r   = press_r_q;

endmodule
